// File: rtl/synth_pkg.sv
// Shared definitions for the poly voice engine: register map, CTRL bit layout,
// datapath widths and the saturating three-way mixer add.
package synth_pkg;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned WAVE_W  = 8;

  typedef enum logic [2:0] {
    REG_FREQ_L = 3'd0,
    REG_FREQ_M = 3'd1,
    REG_FREQ_H = 3'd2,
    REG_DUTY   = 3'd3,
    REG_VOLUME = 3'd4,
    REG_CTRL   = 3'd5
  } reg_ofs_e;

  localparam int unsigned CTRL_W       = 6;
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_SW_GATE = 1;
  localparam int unsigned CTRL_SQ_EN   = 2;
  localparam int unsigned CTRL_SAW_EN  = 3;
  localparam int unsigned CTRL_TRI_EN  = 4;
  localparam int unsigned CTRL_RETRIG  = 5;

  function automatic logic [WAVE_W-1:0] sat_add3(input logic [WAVE_W-1:0] a,
                                                 input logic [WAVE_W-1:0] b,
                                                 input logic [WAVE_W-1:0] c);
    logic [WAVE_W+1:0] s;
    s = (WAVE_W+2)'(a) + (WAVE_W+2)'(b) + (WAVE_W+2)'(c);
    return (s > (WAVE_W+2)'(255)) ? '1 : s[WAVE_W-1:0];
  endfunction

endpackage

// File: rtl/voice_slot_datapath.sv
// Combinational waveform generation, mixing and gain for the voice in the
// current time slot.
module voice_slot_datapath
  import synth_pkg::*;
(
  input  logic [8:0]        phase_hi,
  input  logic [WAVE_W-1:0] duty,
  input  logic [WAVE_W-1:0] volume,
  input  logic              sq_en,
  input  logic              saw_en,
  input  logic              tri_en,
  input  logic              active,
  output logic [WAVE_W-1:0] prod
);

  logic [WAVE_W-1:0]   p;
  logic [WAVE_W-1:0]   sq;
  logic [WAVE_W-1:0]   tri_w;
  logic [WAVE_W-1:0]   mix;
  logic [2*WAVE_W-1:0] product;

  always_comb begin
    p       = phase_hi[8:1];
    sq      = (p < duty) ? '1 : '0;
    // Triangle folds on phase[23] and uses phase[22:15] for twice the slope.
    tri_w   = phase_hi[8] ? ~phase_hi[7:0] : phase_hi[7:0];
    mix     = sat_add3(sq_en  ? sq    : '0,
                       saw_en ? p     : '0,
                       tri_en ? tri_w : '0);
    product = (2*WAVE_W)'(mix) * (2*WAVE_W)'(volume);
    prod    = active ? WAVE_W'(product >> WAVE_W) : '0;
  end

endmodule

// File: rtl/poly_voice_engine.sv
// Time-multiplexed N-voice oscillator engine: per-voice registers, phase
// accumulators and a frame accumulator producing one averaged sample per frame.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned ADDR_W     = $clog2(NUM_VOICES) + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [NUM_VOICES-1:0] gate_in,
  output logic [7:0]            sample_out,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] wrap_pulse
);

  localparam int unsigned LOG2V  = $clog2(NUM_VOICES);
  localparam int unsigned SLOT_W = (LOG2V > 0) ? LOG2V : 1;
  localparam int unsigned ACC_W  = WAVE_W + LOG2V;

  logic [PHASE_W-1:0] freq     [NUM_VOICES];
  logic [7:0]         shadow_l [NUM_VOICES];
  logic [7:0]         shadow_m [NUM_VOICES];
  logic [WAVE_W-1:0]  duty     [NUM_VOICES];
  logic [WAVE_W-1:0]  volume   [NUM_VOICES];
  logic [CTRL_W-1:0]  ctrl     [NUM_VOICES];
  logic [PHASE_W-1:0] phase    [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_hist;

  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  wr_voice;
  logic               slot_first;
  logic               slot_last;
  logic [CTRL_W-1:0]  cur_ctrl;
  logic               cur_gate;
  logic               cur_rise;
  logic [PHASE_W:0]   phase_sum;
  logic [WAVE_W-1:0]  prod;

  logic [WAVE_W-1:0]  prod_q;
  logic               first_q;
  logic               last_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;

  always_comb begin
    voice_active = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      voice_active[v] = ctrl[v][CTRL_EN] & (gate_in[v] | ctrl[v][CTRL_SW_GATE]);
    end
  end

  always_comb begin
    wr_voice   = SLOT_W'(wr_addr >> 3);
    slot_first = (slot == '0);
    slot_last  = (slot == SLOT_W'(NUM_VOICES - 1));
    cur_ctrl   = ctrl[slot];
    cur_gate   = gate_in[slot] | cur_ctrl[CTRL_SW_GATE];
    cur_rise   = cur_gate & ~gate_hist[slot];
    phase_sum  = {1'b0, phase[slot]} + {1'b0, freq[slot]};
    // With first set the frame sum restarts, which also covers NUM_VOICES == 1.
    acc_next   = first_q ? ACC_W'(prod_q) : acc + ACC_W'(prod_q);
  end

  voice_slot_datapath u_datapath (
    .phase_hi (phase[slot][PHASE_W-1:PHASE_W-9]),
    .duty     (duty[slot]),
    .volume   (volume[slot]),
    .sq_en    (cur_ctrl[CTRL_SQ_EN]),
    .saw_en   (cur_ctrl[CTRL_SAW_EN]),
    .tri_en   (cur_ctrl[CTRL_TRI_EN]),
    .active   (voice_active[slot]),
    .prod     (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        freq[v]     <= '0;
        shadow_l[v] <= '0;
        shadow_m[v] <= '0;
        duty[v]     <= '0;
        volume[v]   <= '0;
        ctrl[v]     <= '0;
        phase[v]    <= '0;
      end
      gate_hist    <= '0;
      slot         <= '0;
      prod_q       <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap_pulse   <= '0;
    end else begin
      slot            <= slot_last ? '0 : slot + 1'b1;
      prod_q          <= prod;
      first_q         <= slot_first;
      last_q          <= slot_last;
      gate_hist[slot] <= cur_gate;

      wrap_pulse <= '0;
      if (cur_ctrl[CTRL_EN]) begin
        if (cur_ctrl[CTRL_RETRIG] && cur_rise) begin
          phase[slot] <= '0;
        end else begin
          phase[slot]      <= phase_sum[PHASE_W-1:0];
          wrap_pulse[slot] <= phase_sum[PHASE_W];
        end
      end

      acc          <= acc_next;
      sample_valid <= last_q;
      if (last_q) begin
        sample_out <= acc_next[ACC_W-1:LOG2V];
      end

      // Writes land after the slot read above, so a same-edge write to the
      // active voice takes effect on its next visit.
      if (wr_en) begin
        case (wr_addr[2:0])
          REG_FREQ_L: shadow_l[wr_voice] <= wr_data;
          REG_FREQ_M: shadow_m[wr_voice] <= wr_data;
          REG_FREQ_H: freq[wr_voice]     <= {wr_data, shadow_m[wr_voice], shadow_l[wr_voice]};
          REG_DUTY:   duty[wr_voice]     <= wr_data;
          REG_VOLUME: volume[wr_voice]   <= wr_data;
          REG_CTRL:   ctrl[wr_voice]     <= wr_data[CTRL_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Randomised bench for poly_voice_engine against an integer-level frame model.
module tb_poly_voice_engine;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [NV-1:0] gate_in = '0;
  logic [7:0]    sample_out;
  logic          sample_valid;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] wrap_pulse;

  int n_cmp = 0;
  int n_err = 0;

  poly_voice_engine #(.NUM_VOICES(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .gate_in      (gate_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .voice_active (voice_active),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned m_freq [NV], m_shl [NV], m_shm [NV], m_duty [NV];
  int unsigned m_vol [NV], m_ctrl [NV], m_phase [NV];
  bit          m_gh [NV];
  int unsigned m_slot, m_acc, p_prod;
  bit          p_first, p_last;
  logic [7:0]    m_sample;
  logic          m_valid;
  logic [NV-1:0] m_wrap;

  function automatic logic [NV-1:0] m_active();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++)
      r[v] = ((m_ctrl[v] & 1) != 0) && (gate_in[v] || ((m_ctrl[v] & 2) != 0));
    return r;
  endfunction

  task automatic model_step();
    int unsigned s, p, t, sq, saw, tw, mix, sum, newacc, v, o, d;
    bit g;
    logic [NV-1:0] act;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        m_freq[i] = 0; m_shl[i] = 0; m_shm[i] = 0; m_duty[i] = 0;
        m_vol[i] = 0; m_ctrl[i] = 0; m_phase[i] = 0; m_gh[i] = 0;
      end
      m_slot = 0; m_acc = 0; p_prod = 0; p_first = 0; p_last = 0;
      m_sample = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    act = m_active();
    // frame accumulation of the previous slot's product
    newacc = p_first ? p_prod : m_acc + p_prod;
    m_valid = p_last;
    if (p_last) m_sample = 8'(newacc / NV);
    m_acc = newacc;
    // current slot
    s = m_slot;
    p = m_phase[s] >> 16;
    t = (m_phase[s] >> 15) & 255;
    sq = (p < m_duty[s]) ? 255 : 0;
    saw = p;
    tw = ((m_phase[s] >> 23) & 1) ? 255 - t : t;
    mix = 0;
    if (m_ctrl[s] & 4)  mix += sq;
    if (m_ctrl[s] & 8)  mix += saw;
    if (m_ctrl[s] & 16) mix += tw;
    if (mix > 255) mix = 255;
    p_prod = act[s] ? (mix * m_vol[s]) / 256 : 0;
    p_first = (s == 0);
    p_last = (s == NV - 1);
    m_wrap = 0;
    g = gate_in[s] || ((m_ctrl[s] & 2) != 0);
    if (m_ctrl[s] & 1) begin
      if ((m_ctrl[s] & 32) && g && !m_gh[s]) m_phase[s] = 0;
      else begin
        sum = m_phase[s] + m_freq[s];
        m_wrap[s] = (sum >= 32'h0100_0000);
        m_phase[s] = sum % 32'h0100_0000;
      end
    end
    m_gh[s] = g;
    if (wr_en) begin
      v = wr_addr >> 3; o = wr_addr & 7; d = wr_data;
      case (o)
        0: m_shl[v] = d;
        1: m_shm[v] = d;
        2: m_freq[v] = (d << 16) | (m_shm[v] << 8) | m_shl[v];
        3: m_duty[v] = d;
        4: m_vol[v] = d;
        5: m_ctrl[v] = d & 63;
        default: ;
      endcase
    end
    m_slot = (s + 1) % NV;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d[7:0];
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; gate_in = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int first_k;
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({sample_valid, sample_out, wrap_pulse, voice_active} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b s=%0d w=%b a=%b required all 0",
               sample_valid, sample_out, wrap_pulse, voice_active);
    end
    rst = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (sample_valid && first_k < 0) first_k = k;
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL idle_frames k=%0d: got v=%b s=%0d w=%b a=%b required v=%b s=%0d w=%b a=%b",
                 k, sample_valid, sample_out, wrap_pulse, voice_active,
                 m_valid, m_sample, m_wrap, m_active());
      end
    end
    n_cmp++;
    if (first_k != 5) begin
      n_err++;
      $display("FAIL first_valid_edge: got %0d required 5", first_k);
    end
  endtask

  task automatic test_saw();
    int max_s, wraps;
    do_reset();
    wr(0, 8'h00); wr(1, 8'h00); wr(2, 8'h01); wr(4, 8'hFF); wr(5, 8'h0B);
    max_s = 0; wraps = 0;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (sample_valid && sample_out > max_s) max_s = sample_out;
      if (wrap_pulse[0]) wraps++;
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL saw k=%0d: got v=%b s=%0d w=%b a=%b required v=%b s=%0d w=%b a=%b",
                 k, sample_valid, sample_out, wrap_pulse, voice_active,
                 m_valid, m_sample, m_wrap, m_active());
      end
    end
    n_cmp++;
    if (max_s != 63) begin
      n_err++;
      $display("FAIL saw_peak: got %0d required 63", max_s);
    end
    n_cmp++;
    if (wraps != 1) begin
      n_err++;
      $display("FAIL saw_wrap_count: got %0d required 1", wraps);
    end
  endtask

  task automatic test_freq_atomic();
    wr(0, 8'h00); wr(1, 8'h40);
    for (int k = 0; k < 64; k++) begin
      if (k == 32) wr(2, 8'h03);
      else step();
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL freq_atomic k=%0d: got v=%b s=%0d w=%b required v=%b s=%0d w=%b",
                 k, sample_valid, sample_out, wrap_pulse, m_valid, m_sample, m_wrap);
      end
    end
  endtask

  task automatic test_square_all();
    int max_s;
    do_reset();
    for (int v = 0; v < NV; v++) begin
      wr(v*8+0, 0); wr(v*8+1, 0); wr(v*8+2, 8'h04);
      wr(v*8+3, 8'h80); wr(v*8+4, 8'hFF); wr(v*8+5, 8'h07);
    end
    max_s = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (sample_out > max_s) max_s = sample_out;
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL square_all k=%0d: got v=%b s=%0d w=%b required v=%b s=%0d w=%b",
                 k, sample_valid, sample_out, wrap_pulse, m_valid, m_sample, m_wrap);
      end
    end
    n_cmp++;
    if (max_s != 254) begin
      n_err++;
      $display("FAIL square_peak: got %0d required 254", max_s);
    end
  endtask

  task automatic test_retrig();
    do_reset();
    wr(8, 0); wr(9, 0); wr(10, 8'h80); wr(12, 8'hFF); wr(13, 8'h29);
    for (int k = 0; k < 200; k++) begin
      if (k % 13 == 5) gate_in[1] = ~gate_in[1];
      step();
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL retrig k=%0d: got v=%b s=%0d w=%b a=%b required v=%b s=%0d w=%b a=%b",
                 k, sample_valid, sample_out, wrap_pulse, voice_active,
                 m_valid, m_sample, m_wrap, m_active());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = 8'($urandom);
        if (wr_addr[2:0] == 3'd5) wr_data[0] = ($urandom_range(0, 3) != 0);
      end else begin
        wr_en = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) gate_in = NV'($urandom);
      step();
      n_cmp++;
      if ({sample_valid, sample_out, wrap_pulse, voice_active} !==
          {m_valid, m_sample, m_wrap, m_active()}) begin
        n_err++;
        $display("FAIL random k=%0d: got v=%b s=%0d w=%b a=%b required v=%b s=%0d w=%b a=%b",
                 k, sample_valid, sample_out, wrap_pulse, voice_active,
                 m_valid, m_sample, m_wrap, m_active());
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int first_k;
    for (int k = 0; k < 8 && m_slot != 2; k++) step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({sample_valid, sample_out, wrap_pulse, voice_active} !== 21'd0) begin
      n_err++;
      $display("FAIL mid_reset_state: got v=%b s=%0d w=%b a=%b required all 0",
               sample_valid, sample_out, wrap_pulse, voice_active);
    end
    rst = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sample_valid && first_k < 0) first_k = k;
    end
    n_cmp++;
    if (first_k != 5) begin
      n_err++;
      $display("FAIL mid_reset_first_valid: got %0d required 5", first_k);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_saw();
    test_freq_atomic();
    test_square_all();
    test_retrig();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
